// File: rtl/bsg_fsb_pkg.sv
// Shared definitions for the front-side-bus hop blocks (hop-in and hop-out).
package bsg_fsb_pkg;

  // Channel indices into the per-channel valid/ready vectors.
  localparam int bsg_fsb_ch_local = 0;
  localparam int bsg_fsb_ch_next  = 1;

  // Helpers operate on a 64-bit container so one definition serves every
  // parameterization; callers zero-extend inputs and cast results back.
  localparam int bsg_fsb_max_w_lp = 64;

  // All-ones id of the given width; used as the broadcast destination.
  function automatic logic [bsg_fsb_max_w_lp-1:0] bsg_fsb_bcast_id(input int id_w);
    return (64'd1 << id_w) - 64'd1;
  endfunction

  // Destination id sits in the top id_w bits of a width-bit packet.
  function automatic logic [bsg_fsb_max_w_lp-1:0] bsg_fsb_dst(
    input logic [bsg_fsb_max_w_lp-1:0] data,
    input int                          width,
    input int                          id_w
  );
    logic [bsg_fsb_max_w_lp-1:0] mask;
    mask = (64'd1 << id_w) - 64'd1;
    return (data >> (width - id_w)) & mask;
  endfunction

endpackage

// File: rtl/bsg_fsb_two_fifo_async_reset.sv
// Two-entry FIFO, ready/valid on the input, valid/yumi on the output.
// Full/empty are registered so ready_o and v_o never see a combinational
// path from the opposite handshake. Storage itself is not reset.
module bsg_fsb_two_fifo_async_reset
  import bsg_fsb_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               head_q, head_d;
  logic               tail_q, tail_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               enq, deq;

  assign ready_o = ~full_q;
  assign v_o     = ~empty_q;
  assign data_o  = mem_q[head_q];

  // A full FIFO refuses input even when the head leaves this cycle.
  assign enq = v_i & ~full_q;
  assign deq = yumi_i & ~empty_q;

  // Next-state pointers and occupancy flags.
  always_comb begin
    head_d  = head_q ^ deq;
    tail_d  = tail_q ^ enq;
    full_d  = full_q;
    empty_d = empty_q;
    unique case ({enq, deq})
      2'b10: begin
        full_d  = ((tail_q ^ 1'b1) == head_q);
        empty_d = 1'b0;
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = ((head_q ^ 1'b1) == tail_q);
      end
      default: ;
    endcase
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Payload storage; written at the tail on enqueue.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[tail_q] <= data_i;
  end

endmodule

// File: rtl/bsg_front_side_bus_hop_in.sv
// Front-side-bus hop receive side: buffers the upstream stream in a
// two-entry FIFO and steers the head packet to the local node (ch 0) or
// the next hop (ch 1) by its destination id.
// Optional: define BSG_FSB_HOP_IN_BROADCAST_EN to deliver the all-ones id
// to both channels, tracking partial delivery in sent_q.
module bsg_front_side_bus_hop_in
  import bsg_fsb_pkg::*;
#(
  parameter int width_p    = 16,
  parameter int id_width_p = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [id_width_p-1:0] local_id_i,
  input  logic                  v_i,
  input  logic [width_p-1:0]    data_i,
  output logic                  ready_o,
  output logic [1:0]            v_o,
  output logic [width_p-1:0]    data_o,
  input  logic [1:0]            ready_i
);

  logic                  fifo_v;
  logic                  fifo_yumi;
  logic [width_p-1:0]    fifo_data;
  logic [id_width_p-1:0] dst;
  logic [1:0]            want;
  logic [1:0]            sent;
  logic [1:0]            fire;

  bsg_fsb_two_fifo_async_reset #(
    .width_p (width_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (v_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .v_o       (fifo_v),
    .data_o    (fifo_data),
    .yumi_i    (fifo_yumi)
  );

  assign dst    = id_width_p'(bsg_fsb_dst(64'(fifo_data), width_p, id_width_p));
  assign data_o = fifo_data;

  // Channel request mask for the head packet.
  always_comb begin
    want = 2'b00;
`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
    if (dst == id_width_p'(bsg_fsb_bcast_id(id_width_p))) begin
      want = 2'b11;
    end else
`endif
    if (dst == local_id_i) begin
      want[bsg_fsb_ch_local] = 1'b1;
    end else begin
      want[bsg_fsb_ch_next] = 1'b1;
    end
  end

  // Valid never looks at ready_i; channels already served drop out.
  assign v_o  = {2{fifo_v}} & want & ~sent;
  assign fire = v_o & ready_i;

  // Head leaves once every wanted channel has fired now or earlier.
  assign fifo_yumi = fifo_v & ((want & ~(sent | fire)) == 2'b00);

`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
  logic [1:0] sent_q, sent_d;

  // Remember channels served by a broadcast still waiting on the other.
  always_comb begin
    sent_d = sent_q | fire;
    if (fifo_yumi) sent_d = 2'b00;
  end

  // Partial-delivery record; abandoned on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sent_q <= 2'b00;
    else            sent_q <= sent_d;
  end

  assign sent = sent_q;
`else
  assign sent = 2'b00;
`endif

endmodule

// File: tb/tb_bsg_front_side_bus_hop_in.sv
// Self-checking bench for bsg_front_side_bus_hop_in (local id 4'h3).
// Per-channel scoreboard queues are filled as packets are accepted and
// drained by a monitor whenever a channel fires.
module tb_bsg_front_side_bus_hop_in;

  localparam logic [3:0] LOCAL = 4'h3;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  local_id_i;
  logic        v_i;
  logic [15:0] data_i;
  logic        ready_o;
  logic [1:0]  v_o;
  logic [15:0] data_o;
  logic [1:0]  ready_i;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  bsg_front_side_bus_hop_in #(.width_p(16), .id_width_p(4)) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .local_id_i (local_id_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .ready_i    (ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Expected routing derived from the packet's top nibble.
  task automatic push_exp(input logic [15:0] d);
`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
    if (d[15:12] == 4'hF) begin
      q0.push_back(d);
      q1.push_back(d);
    end else
`endif
    if (d[15:12] == LOCAL) q0.push_back(d);
    else                   q1.push_back(d);
  endtask

  // Offer one packet until it is taken (bounded).
  task automatic send(input logic [15:0] d);
    bit acc;
    acc    = 1'b0;
    v_i    = 1'b1;
    data_i = d;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk_i);
      if (ready_o) begin
        acc = 1'b1;
        push_exp(d);
      end
      tick();
    end
    v_i = 1'b0;
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  // Scoreboard monitor: every firing channel must match its queue head.
  always @(negedge clk_i) begin
    if (reset_n_i === 1'b1) begin
      if (v_o[0] && ready_i[0]) begin
        if (q0.size() == 0) chk("ch0_unexpected", 32'(q0.size()), 32'd1);
        else                chk("ch0_data", 32'(data_o), 32'(q0.pop_front()));
      end
      if (v_o[1] && ready_i[1]) begin
        if (q1.size() == 0) chk("ch1_unexpected", 32'(q1.size()), 32'd1);
        else                chk("ch1_data", 32'(data_o), 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i  = 1'b1;
    local_id_i = LOCAL;
    v_i        = 1'b0;
    data_i     = 16'h0;
    ready_i    = 2'b00;
    #1 reset_n_i = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_v", 32'(v_o), 32'd0);
    tick(); tick();
    reset_n_i = 1'b1;
    tick();

    // Local delivery
    ready_i = 2'b11;
    send(16'h3ABC);
    @(negedge clk_i);
    chk("local_v", 32'(v_o), 32'd1);
    chk("local_data", 32'(data_o), 32'h3ABC);
    tick();
    @(negedge clk_i);
    chk("local_drained", 32'(v_o), 32'd0);
    tick();

    // Pass-through streaming
    ready_i = 2'b10;
    send(16'h5123);
    send(16'h6456);
    @(negedge clk_i);
    chk("stream_v", 32'(v_o), 32'd2);
    chk("stream_data", 32'(data_o), 32'h6456);
    chk("stream_ready", 32'(ready_o), 32'd1);
    tick();
    @(negedge clk_i);
    chk("stream_drained", 32'(v_o), 32'd0);
    tick();

    // Backpressure: two buffered, third held
    ready_i = 2'b00;
    send(16'h3001);
    send(16'h5002);
    @(negedge clk_i);
    chk("bp_full", 32'(ready_o), 32'd0);
    tick();
    v_i = 1'b1;
    data_i = 16'h3003;
    tick(); tick();
    @(negedge clk_i);
    chk("bp_held", 32'(ready_o), 32'd0);
    chk("bp_head_v", 32'(v_o), 32'd1);
    chk("bp_head_data", 32'(data_o), 32'h3001);
    tick();
    v_i = 1'b0;
    ready_i = 2'b11;
    send(16'h3003);
    repeat (4) tick();
    chk("bp_q0_empty", 32'(q0.size()), 32'd0);
    chk("bp_q1_empty", 32'(q1.size()), 32'd0);

    // Head-of-line blocking
    ready_i = 2'b10;
    send(16'h3111);
    send(16'h5222);
    tick();
    @(negedge clk_i);
    chk("hol_v", 32'(v_o), 32'd1);
    chk("hol_data", 32'(data_o), 32'h3111);
    tick();
    ready_i = 2'b11;
    @(negedge clk_i);
    chk("hol_first_v", 32'(v_o), 32'd1);
    chk("hol_first_data", 32'(data_o), 32'h3111);
    tick();
    @(negedge clk_i);
    chk("hol_second_v", 32'(v_o), 32'd2);
    chk("hol_second_data", 32'(data_o), 32'h5222);
    tick();
    @(negedge clk_i);
    chk("hol_drained", 32'(v_o), 32'd0);
    tick();

    // All-ones destination
`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
    ready_i = 2'b01;
    send(16'hF00D);
    @(negedge clk_i);
    chk("bc_both_v", 32'(v_o), 32'd3);
    tick();
    ready_i = 2'b10;
    @(negedge clk_i);
    chk("bc_partial_v", 32'(v_o), 32'd2);
    chk("bc_partial_data", 32'(data_o), 32'hF00D);
    tick();
    @(negedge clk_i);
    chk("bc_done", 32'(v_o), 32'd0);
    tick();
    ready_i = 2'b11;
    send(16'hF00D);
    @(negedge clk_i);
    chk("bc_single_v", 32'(v_o), 32'd3);
    tick();
    @(negedge clk_i);
    chk("bc_single_done", 32'(v_o), 32'd0);
    tick();
`else
    ready_i = 2'b00;
    send(16'hF00D);
    @(negedge clk_i);
    chk("ff_next_only", 32'(v_o), 32'd2);
    tick();
    ready_i = 2'b10;
    tick();
    @(negedge clk_i);
    chk("ff_done", 32'(v_o), 32'd0);
    tick();
`endif

    // Reset mid-operation with a full FIFO
    ready_i = 2'b00;
`ifdef BSG_FSB_HOP_IN_BROADCAST_EN
    send(16'hF00D);
    send(16'h3555);
    ready_i = 2'b01;
    tick();
    ready_i = 2'b00;
`else
    send(16'h5AAA);
    send(16'h3BBB);
`endif
    @(negedge clk_i);
    chk("mid_full", 32'(ready_o), 32'd0);
    #2 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_v", 32'(v_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    q0.delete();
    q1.delete();
    tick();
    reset_n_i = 1'b1;
    ready_i = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("post_rst_idle", 32'(v_o), 32'd0);
      tick();
    end

    chk("final_q0", 32'(q0.size()), 32'd0);
    chk("final_q1", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_front_side_bus_hop_in.md
Name: bsg_front_side_bus_hop_in

Overview:
- Receive side of a front-side-bus hop. Accepts one 16-bit packet stream from the upstream hop and buffers it in a two-entry FIFO.
- Steers each packet by its destination-id field either to the local node (channel 0) or onward to the next hop (channel 1).
- With the optional feature compiled in, a broadcast id is delivered to both channels.
- Mirrors the hop-out block, which merges local and through traffic onto the bus.

Parameters:
- width_p, 16, packet width in bits.
- id_width_p, 4, width of the destination-id field, which occupies data bits [width_p-1 -: id_width_p].

Ports:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  one clock; reset is asynchronous and active-low.
- local_id_i  in  id_width_p  this node's id; quasi-static, changes only while reset_n_i=0.
- v_i  in  1  upstream packet valid.
- data_i  in  width_p  upstream packet.
- ready_o  out  1  buffer can accept; transfer when v_i & ready_o.
- v_o  out  2  per-channel valid; [0]=local, [1]=next hop.
- data_o  out  width_p  FIFO head packet, shared by both channels.
- ready_i  in  2  per-channel downstream ready; channel i fires when v_o[i] & ready_i[i].

Behaviour:
- Reset (asynchronous, effective immediately while reset_n_i=0):
  - FIFO empty, head=tail=0, sent_r=00.
  - Outputs: ready_o=1, v_o=00.
  - data_o is don't-care whenever v_o=00; storage is not reset.
- Buffer: two-entry FIFO with registered full/empty flags.
  - ready_o = ~full. No enqueue when full, even if a dequeue occurs in the same cycle.
  - Enqueue and dequeue in the same cycle are allowed when neither full nor empty.
  - Head and tail pointers wrap 1->0.
- Latency and throughput:
  - A packet accepted in cycle N is presented at the earliest in cycle N+1.
  - One packet per cycle sustained when the target channel is ready.
- Steering, from the head packet's destination field dst:
  - want = 01 if dst==local_id_i; otherwise want = 10.
  - v_o[i] = ~empty & want[i] & ~sent_r[i].
- Dequeue: occurs when every bit of want is either already set in sent_r or fires this cycle. On dequeue, sent_r is cleared to 00.
- Partial delivery (broadcast only): channels that fire without completing delivery set their sent_r bit. The other channel keeps v_o asserted until it fires.
- Ordering and blocking:
  - Strict in-order delivery.
  - Head-of-line blocking is intended: a blocked head stalls the packet behind it, even if that packet targets the other channel.
- Handshake rules:
  - v_o depends only on registered state and local_id_i, never on ready_i.
  - ready_o depends only on registered state.
  - No combinational path from v_i or ready_i to ready_o.
- Reset mid-operation: buffered packets are discarded, and any partial broadcast is abandoned (sent_r=00).

Optional Feature:
- Macro: BSG_FSB_HOP_IN_BROADCAST_EN.
- Defined: dst == all-ones gives want=11. The packet is dequeued once both channels have fired, in the same cycle or in different cycles, tracked via sent_r.
- Undefined:
  - All-ones is an ordinary id: routed to channel 0 only if it equals local_id_i, else to channel 1.
  - sent_r and its logic are absent; v_o never equals 11.

Decomposition:
- Shared package bsg_fsb_pkg:
  - Channel index constants bsg_fsb_ch_local=0 and bsg_fsb_ch_next=1.
  - Broadcast-id function returning all-ones of id_width_p.
  - Dest-field extraction function.
- Sub-module bsg_fsb_two_fifo_async_reset (width_p): two-entry FIFO with asynchronous active-low reset and ready/valid/yumi interface, reusable by the hop-out block.
- Steering, sent_r and dequeue logic live in the top module.

Test Plan (width_p=16, id_width_p=4, local_id_i=4'h3):
- Reset and local delivery: reset_n_i=0 -> ready_o=1, v_o=00 asynchronously. After release, push 16'h3ABC with ready_i=11 -> next cycle v_o=01, data_o=16'h3ABC; dequeued that cycle.
- Pass-through streaming: push 16'h5123 then 16'h6456 back-to-back with ready_i=10 -> v_o=10 on consecutive cycles with data in order; ready_o stays 1.
- Backpressure: ready_i=00, offer 16'h3001, 16'h5002, 16'h3003 -> first two accepted, ready_o=0, third held. Set ready_i=11 -> delivered 3001(ch0), 5002(ch1), 3003(ch0) in order. No loss, no duplication.
- Head-of-line: head 16'h3111 with ready_i=10, second 16'h5222 queued -> v_o=01 persists, 5222 not presented. ready_i=11 -> 3111 then 5222.
- Broadcast (macro defined): push 16'hF00D, ready_i=01 -> v_o=11, ch0 fires, next cycle v_o=10. ready_i=10 -> ch1 fires and packet dequeued. Repeat with ready_i=11 -> single-cycle dequeue. With macro undefined -> v_o=10 only.
- Reset mid-operation: FIFO full with partial broadcast pending, drop reset_n_i mid-cycle -> v_o=00, ready_o=1 immediately. After release, no stale packet is presented.
